// File: rtl/capsense_scanner.sv
// -----------------------------------------------------------------------------
// capsense_scanner
//
// Scans NUM_SENSE capacitive touch pads one at a time. All pads are held low
// (discharged). Then one pad is released and the scanner counts the clocks
// until that pad reads high. The count is compared against a threshold with
// hysteresis to produce a touch flag for each pad.
//
// Sequence per channel: DISCHARGE (DISCHARGE_CYCLES clocks, all pads low),
// then CHARGE (the selected pad is released and the counter runs), then
// EVAL (one clock, the result is stored). After the last channel the block
// pulses scan_done and returns to IDLE. It rescans while enable stays high.
//
// Pad inputs pass through a 2-flop synchronizer. Every count therefore
// includes a fixed +2 offset.
//
// Optional feature: define CAPSENSE_FILTER_EN to require 3 consecutive
// agreeing evaluations before a channel's touch flag changes.
//
// Ports:
//   clk        : single clock
//   reset_n    : asynchronous active-low reset
//   enable     : run continuous scans while high
//   threshold  : touch-set level (count >= threshold sets touch)
//   hysteresis : touch-clear margin (count < threshold-hysteresis clears)
//   sense_in   : raw pad levels, asynchronous
//   sense_oe   : per-pad drive enable, 1 = pad driven low
//   touch      : per-channel touch flags
//   timeout    : last measurement of that channel hit TIMEOUT_CNT
//   rd_sel     : channel select for count readback
//   rd_count   : last stored count of channel rd_sel (combinational)
//   scan_done  : one-clock pulse after the last channel is evaluated
// -----------------------------------------------------------------------------
module capsense_scanner #(
  parameter int                   NUM_SENSE        = 4,
  parameter int                   CNT_WIDTH        = 16,
  parameter int                   DISCHARGE_CYCLES = 64,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_CNT      = 16'hFFF0,
  localparam int                  SEL_W            = (NUM_SENSE > 1) ? $clog2(NUM_SENSE) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [CNT_WIDTH-1:0] hysteresis,
  input  logic [NUM_SENSE-1:0] sense_in,
  output logic [NUM_SENSE-1:0] sense_oe,
  output logic [NUM_SENSE-1:0] touch,
  output logic [NUM_SENSE-1:0] timeout,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 scan_done
);

  typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, EVAL} state_t;

  localparam logic [CNT_WIDTH-1:0] DIS_LAST = CNT_WIDTH'(DISCHARGE_CYCLES - 1);
  localparam logic [SEL_W-1:0]     LAST_CH  = SEL_W'(NUM_SENSE - 1);

  state_t               state;
  logic [SEL_W-1:0]     ch;
  logic [CNT_WIDTH-1:0] cnt;
  logic [NUM_SENSE-1:0] sync_meta;
  logic [NUM_SENSE-1:0] sync_in;
  logic [CNT_WIDTH-1:0] counts [NUM_SENSE];

`ifdef CAPSENSE_FILTER_EN
  // Per-channel count of consecutive evaluations that disagree with touch.
  logic [1:0]           agree [NUM_SENSE];
`endif

  // Evaluation of the current count. It is only consumed in EVAL, so the
  // threshold and hysteresis inputs take effect only there.
  logic [CNT_WIDTH-1:0] clear_lvl;
  logic                 hit_timeout;
  logic                 want_touch;

  // NOTE: every output of a combinational block gets a default first, so that
  //       no path leaves it unassigned and infers a latch.
  always_comb begin
    clear_lvl   = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
    hit_timeout = (cnt == TIMEOUT_CNT);
    want_touch  = touch[ch];
    if (hit_timeout || (cnt >= threshold)) begin
      want_touch = 1'b1;
    end else if (cnt < clear_lvl) begin
      want_touch = 1'b0;
    end
  end

  assign rd_count = counts[rd_sel];

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  //       sample their inputs before any of them update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ch        <= '0;
      cnt       <= '0;
      sync_meta <= '0;
      sync_in   <= '0;
      sense_oe  <= '1;
      touch     <= '0;
      timeout   <= '0;
      scan_done <= 1'b0;
      // NOTE: the stored counts are readable through rd_count, so this small
      //       memory is explicitly cleared by reset rather than left unknown.
      for (int i = 0; i < NUM_SENSE; i++) begin
        counts[i] <= '0;
`ifdef CAPSENSE_FILTER_EN
        agree[i]  <= '0;
`endif
      end
    end else begin
      sync_meta <= sense_in;
      sync_in   <= sync_meta;
      scan_done <= 1'b0;

      if (!enable) begin
        // Abort: discard the partial count and keep all stored results.
        state    <= IDLE;
        cnt      <= '0;
        sense_oe <= '1;
      end else begin
        case (state)
          IDLE: begin
            ch    <= '0;
            cnt   <= '0;
            state <= DISCHARGE;
          end

          DISCHARGE: begin
            if (cnt == DIS_LAST) begin
              cnt          <= '0;
              sense_oe[ch] <= 1'b0;
              state        <= CHARGE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          CHARGE: begin
            // Leaving at TIMEOUT_CNT without incrementing gives saturation.
            if (sync_in[ch] || (cnt == TIMEOUT_CNT)) begin
              sense_oe <= '1;
              state    <= EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          EVAL: begin
            counts[ch]  <= cnt;
            timeout[ch] <= hit_timeout;
`ifdef CAPSENSE_FILTER_EN
            if (want_touch != touch[ch]) begin
              if (agree[ch] == 2'd2) begin
                touch[ch] <= want_touch;
                agree[ch] <= 2'd0;
              end else begin
                agree[ch] <= agree[ch] + 2'd1;
              end
            end else begin
              agree[ch] <= 2'd0;
            end
`else
            touch[ch]   <= want_touch;
`endif
            cnt <= '0;
            if (ch != LAST_CH) begin
              ch    <= ch + 1'b1;
              state <= DISCHARGE;
            end else begin
              scan_done <= 1'b1;
              state     <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capsense_scanner.sv
// -----------------------------------------------------------------------------
// tb_capsense_scanner
//
// Self-checking bench for capsense_scanner. A pad model raises each pad a
// chosen number of clocks after the scanner releases it. A reference model
// predicts each channel's stored count, timeout flag and touch flag from
// the pad delay, threshold and hysteresis. It honours CAPSENSE_FILTER_EN
// when that macro is defined.
// -----------------------------------------------------------------------------
module tb_capsense_scanner;

  localparam int          N     = 4;
  localparam int          W     = 16;
  localparam int          D     = 64;
  localparam int unsigned TO    = 32'h0000_FFF0;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;
  localparam int          LIMIT = 70000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] threshold;
  logic [W-1:0] hysteresis;
  logic [N-1:0] sense_in;
  logic [N-1:0] sense_oe;
  logic [N-1:0] touch;
  logic [N-1:0] timeout;
  logic [1:0]   rd_sel;
  logic [W-1:0] rd_count;
  logic         scan_done;

  capsense_scanner #(
    .NUM_SENSE(N), .CNT_WIDTH(W), .DISCHARGE_CYCLES(D), .TIMEOUT_CNT(16'hFFF0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .threshold(threshold),
    .hysteresis(hysteresis), .sense_in(sense_in), .sense_oe(sense_oe),
    .touch(touch), .timeout(timeout), .rd_sel(rd_sel), .rd_count(rd_count),
    .scan_done(scan_done)
  );

  always #10 clk = ~clk;

  // Pad model: a pad reads low while driven low. Once released, it reads high
  // after delay[i] clocks.
  int unsigned delay [N];
  int unsigned rel   [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) rel[i] <= sense_oe[i] ? 0 : rel[i] + 1;
  end

  always_comb begin
    for (int i = 0; i < N; i++) sense_in[i] = !sense_oe[i] && (rel[i] >= delay[i]);
  end

  // Reference model state
  int unsigned m_count  [N];
  bit          m_to     [N];
  bit          m_touch  [N];
  int          m_streak [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_count[i] = 0; m_to[i] = 0; m_touch[i] = 0; m_streak[i] = 0;
    end
  endtask

  // One evaluation of channel c: the count is the pad delay plus the
  // synchronizer latency, capped at the timeout value.
  task automatic model_eval(input int c, input int unsigned thr, input int unsigned hys);
    int unsigned cnt;
    int unsigned lo;
    bit want;
    cnt  = (delay[c] >= TO - 2) ? TO : delay[c] + 2;
    lo   = (thr > hys) ? thr - hys : 0;
    want = m_touch[c];
    if (cnt == TO || cnt >= thr) want = 1'b1;
    else if (cnt < lo)           want = 1'b0;
    m_count[c] = cnt;
    m_to[c]    = (cnt == TO);
`ifdef CAPSENSE_FILTER_EN
    if (want != m_touch[c]) begin
      m_streak[c]++;
      if (m_streak[c] == 3) begin
        m_touch[c]  = want;
        m_streak[c] = 0;
      end
    end else begin
      m_streak[c] = 0;
    end
`else
    m_touch[c] = want;
`endif
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_sel = 2'(i);
      #1;
      check($sformatf("%s count[%0d]", tag, i), 32'(rd_count), m_count[i]);
      check($sformatf("%s timeout[%0d]", tag, i), 32'(timeout[i]), 32'(m_to[i]));
      check($sformatf("%s touch[%0d]", tag, i), 32'(touch[i]), 32'(m_touch[i]));
    end
  endtask

  // Runs one complete scan and stops before the next scan begins.
  task automatic run_scan(input string tag, input int unsigned thr, input int unsigned hys);
    bit done;
    done       = 1'b0;
    threshold  = W'(thr);
    hysteresis = W'(hys);
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (scan_done) begin
        done = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    check({tag, " scan_done seen"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, " scan_done single pulse"}, 32'(scan_done), 32'd0);
    for (int i = 0; i < N; i++) model_eval(i, thr, hys);
    check_all(tag);
  endtask

  task automatic wait_oe(input string tag, input logic [N-1:0] val);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (sense_oe == val) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " sense_oe pattern reached"}, 32'(seen), 32'd1);
  endtask

  task automatic set_delays(input int unsigned d0, input int unsigned d1,
                            input int unsigned d2, input int unsigned d3);
    delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3;
  endtask

  initial begin
    int pulses;
    reset_n    = 1'b0;
    enable     = 1'b0;
    threshold  = '0;
    hysteresis = '0;
    rd_sel     = '0;
    set_delays(0, 0, 0, 0);
    model_reset();

    repeat (3) @(negedge clk);
    check("reset sense_oe", 32'(sense_oe), 32'hF);
    check("reset touch", 32'(touch), 32'h0);
    check("reset timeout", 32'(timeout), 32'h0);
    check("reset scan_done", 32'(scan_done), 32'h0);
    reset_n = 1'b1;
    check_all("reset");

    // Set, hold inside the hysteresis band, then clear.
    set_delays(150, 20, 30, 40);
    run_scan("pad0 150", 100, 10);
    rd_sel = 2'd0; #1;
    check("pad0 150 rd_count", 32'(rd_count), 32'd152);
`ifndef CAPSENSE_FILTER_EN
    check("pad0 150 touch", 32'(touch[0]), 32'd1);
`endif
    set_delays(95, 20, 30, 40);
    run_scan("pad0 95", 100, 10);
    rd_sel = 2'd0; #1;
    check("pad0 95 rd_count", 32'(rd_count), 32'd97);
`ifndef CAPSENSE_FILTER_EN
    check("pad0 95 touch held", 32'(touch[0]), 32'd1);
`endif
    set_delays(80, 20, 30, 40);
    run_scan("pad0 80", 100, 10);
    rd_sel = 2'd0; #1;
    check("pad0 80 rd_count", 32'(rd_count), 32'd82);
`ifndef CAPSENSE_FILTER_EN
    check("pad0 80 touch cleared", 32'(touch[0]), 32'd0);
`endif

    // Pad 2 never rises: the count saturates.
    set_delays(40, 40, NEVER, 40);
    run_scan("pad2 stuck", 100, 10);
    rd_sel = 2'd2; #1;
    check("pad2 saturated count", 32'(rd_count), 32'hFFF0);
    check("pad2 timeout", 32'(timeout[2]), 32'd1);
`ifndef CAPSENSE_FILTER_EN
    check("pad2 touch", 32'(touch[2]), 32'd1);
`endif

    // Randomized scans, including hysteresis larger than threshold.
    for (int s = 0; s < 8; s++) begin
      int unsigned thr;
      int unsigned hys;
      thr = $urandom_range(0, 300);
      hys = $urandom_range(0, 150);
      for (int i = 0; i < N; i++) delay[i] = $urandom_range(0, 320);
      run_scan($sformatf("rand%0d", s), thr, hys);
    end

    // Drop enable while channel 1 is charging.
    set_delays(50, 200, 30, 30);
    threshold  = 16'd100;
    hysteresis = 16'd10;
    @(negedge clk);
    enable = 1'b1;
    wait_oe("abort", 4'b1101);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort sense_oe idle", 32'(sense_oe), 32'hF);
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (scan_done) pulses++;
    end
    check("abort no scan_done", 32'(pulses), 32'd0);
    check("abort sense_oe stays idle", 32'(sense_oe), 32'hF);
    model_eval(0, 100, 10);
    check_all("abort");

    // Assert reset mid-DISCHARGE of channel 2, with no clock edge before checking.
    set_delays(30, 30, 30, 30);
    @(negedge clk);
    enable = 1'b1;
    wait_oe("mid reset ch1", 4'b1101);
    wait_oe("mid reset ch2 discharge", 4'b1111);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async reset sense_oe", 32'(sense_oe), 32'hF);
    check("async reset touch", 32'(touch), 32'h0);
    check("async reset timeout", 32'(timeout), 32'h0);
    check("async reset scan_done", 32'(scan_done), 32'h0);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("async reset count[%0d]", i), 32'(rd_count), 32'h0);
    end
    enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

`ifdef CAPSENSE_FILTER_EN
    // Touch flips only on the third agreeing scan, and an alternating
    // pattern never flips it back.
    set_delays(150, 10, 10, 10);
    run_scan("filt1", 100, 10);
    check("filter scan1 touch", 32'(touch[0]), 32'd0);
    run_scan("filt2", 100, 10);
    check("filter scan2 touch", 32'(touch[0]), 32'd0);
    run_scan("filt3", 100, 10);
    check("filter scan3 touch", 32'(touch[0]), 32'd1);
    for (int s = 0; s < 6; s++) begin
      delay[0] = (s % 2 == 0) ? 20 : 150;
      run_scan($sformatf("alt%0d", s), 100, 10);
      check($sformatf("filter alternating %0d touch", s), 32'(touch[0]), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
